// File: rtl/hazard_pkg.sv
// Shared constants for the hazard/forwarding controller: timing encodings,
// MDU latency defaults and forwarding-source select codes.
package hazard_pkg;

  localparam int TNEW_W = 2;

  localparam logic [TNEW_W-1:0] TNEW_0 = 2'd0;
  localparam logic [TNEW_W-1:0] TNEW_1 = 2'd1;
  localparam logic [TNEW_W-1:0] TNEW_2 = 2'd2;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  // Forwarding sources, listed from highest to lowest priority.
  typedef enum logic [2:0] {
    FWD_ZERO = 3'd0,
    FWD_EX   = 3'd1,
    FWD_MEM  = 3'd2,
    FWD_WB   = 3'd3,
    FWD_PIPE = 3'd4
  } fwd_sel_e;

endpackage

// File: rtl/md_busy_tracker.sv
// Multiply/divide busy down-counter. A start while busy is dropped and latched
// in the sticky md_err flag.
import hazard_pkg::*;

module md_busy_tracker #(
  parameter int MULT_CYC = hazard_pkg::MULT_CYC_DEF,
  parameter int DIV_CYC  = hazard_pkg::DIV_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_start,
  input  logic md_div,
  output logic md_busy
);

  logic [CNT_W-1:0] md_cnt;
  logic             md_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt <= '0;
      md_err <= 1'b0;
    end else if (md_start && (md_cnt == '0)) begin
      md_cnt <= md_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else begin
      md_err <= md_err | md_start;
      if (md_cnt != '0) md_cnt <= md_cnt - 1'b1;
    end
  end

  assign md_busy = (md_cnt != '0);

endmodule

// File: rtl/hazard_ctrl_mdu.sv
// Pipeline hazard detection, operand forwarding and MDU stall control.
// Optional stall performance counters are enabled by HAZARD_PERF_CNT_EN.
import hazard_pkg::*;

module hazard_ctrl_mdu #(
  parameter int DATA_W   = 32,
  parameter int REG_AW   = 5,
  parameter int TNEW_W   = hazard_pkg::TNEW_W,
  parameter int MULT_CYC = hazard_pkg::MULT_CYC_DEF,
  parameter int DIV_CYC  = hazard_pkg::DIV_CYC_DEF,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [TNEW_W-1:0] id_rs_tuse,
  input  logic [TNEW_W-1:0] id_rt_tuse,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              id_is_md,
  input  logic [REG_AW-1:0] ex_rs_addr,
  input  logic [REG_AW-1:0] ex_rt_addr,
  input  logic [DATA_W-1:0] ex_rs_data,
  input  logic [DATA_W-1:0] ex_rt_data,
  input  logic [REG_AW-1:0] ex_wa,
  input  logic [TNEW_W-1:0] ex_tnew,
  input  logic [DATA_W-1:0] ex_wd,
  input  logic              ex_md_start,
  input  logic              ex_md_div,
  input  logic [REG_AW-1:0] mem_rt_addr,
  input  logic [DATA_W-1:0] mem_rt_data,
  input  logic [REG_AW-1:0] mem_wa,
  input  logic [TNEW_W-1:0] mem_tnew,
  input  logic [DATA_W-1:0] mem_wd,
  input  logic [REG_AW-1:0] wb_wa,
  input  logic [DATA_W-1:0] wb_wd,
  output logic [DATA_W-1:0] id_rs_fwd,
  output logic [DATA_W-1:0] id_rt_fwd,
  output logic [DATA_W-1:0] ex_rs_fwd,
  output logic [DATA_W-1:0] ex_rt_fwd,
  output logic [DATA_W-1:0] mem_rt_fwd,
  output logic              stall,
  output logic              en_pc,
  output logic              en_if_id,
  output logic              flush_id_ex,
  output logic              md_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       data_stall_cnt,
  output logic [31:0]       md_stall_cnt
`endif
);

  logic data_stall;
  logic md_stall;

  // A source must wait while its producer needs more cycles than it can spare.
  function automatic logic raw_hit(input logic [REG_AW-1:0] addr,
                                   input logic [TNEW_W-1:0] tuse,
                                   input logic [REG_AW-1:0] wa,
                                   input logic [TNEW_W-1:0] tnew);
    return (addr != '0) && (addr == wa) && (tuse < tnew);
  endfunction

  function automatic fwd_sel_e sel_id(input logic [REG_AW-1:0] addr);
    if (addr == '0)                             return FWD_ZERO;
    else if (addr == ex_wa && ex_tnew == '0)    return FWD_EX;
    else if (addr == mem_wa && mem_tnew == '0)  return FWD_MEM;
    else if (addr == wb_wa)                     return FWD_WB;
    else                                        return FWD_PIPE;
  endfunction

  function automatic fwd_sel_e sel_ex(input logic [REG_AW-1:0] addr);
    if (addr == '0)                             return FWD_ZERO;
    else if (addr == mem_wa && mem_tnew == '0)  return FWD_MEM;
    else if (addr == wb_wa)                     return FWD_WB;
    else                                        return FWD_PIPE;
  endfunction

  function automatic fwd_sel_e sel_mem(input logic [REG_AW-1:0] addr);
    if (addr == '0)         return FWD_ZERO;
    else if (addr == wb_wa) return FWD_WB;
    else                    return FWD_PIPE;
  endfunction

  function automatic logic [DATA_W-1:0] fwd_mux(input fwd_sel_e sel,
                                                input logic [DATA_W-1:0] pipe);
    case (sel)
      FWD_EX:   return ex_wd;
      FWD_MEM:  return mem_wd;
      FWD_WB:   return wb_wd;
      FWD_PIPE: return pipe;
      default:  return '0;
    endcase
  endfunction

  always_comb begin
    id_rs_fwd  = fwd_mux(sel_id(id_rs_addr), id_rs_data);
    id_rt_fwd  = fwd_mux(sel_id(id_rt_addr), id_rt_data);
    ex_rs_fwd  = fwd_mux(sel_ex(ex_rs_addr), ex_rs_data);
    ex_rt_fwd  = fwd_mux(sel_ex(ex_rt_addr), ex_rt_data);
    mem_rt_fwd = fwd_mux(sel_mem(mem_rt_addr), mem_rt_data);
  end

  assign data_stall = raw_hit(id_rs_addr, id_rs_tuse, ex_wa, ex_tnew)
                    | raw_hit(id_rs_addr, id_rs_tuse, mem_wa, mem_tnew)
                    | raw_hit(id_rt_addr, id_rt_tuse, ex_wa, ex_tnew)
                    | raw_hit(id_rt_addr, id_rt_tuse, mem_wa, mem_tnew);

  // The start term covers the cycle before the counter becomes visible.
  assign md_stall    = id_is_md && (md_busy || ex_md_start);
  assign stall       = data_stall || md_stall;
  assign en_pc       = !stall;
  assign en_if_id    = !stall;
  assign flush_id_ex = stall;

  md_busy_tracker #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC),
    .CNT_W    (CNT_W)
  ) u_tracker (
    .clk      (clk),
    .reset    (reset),
    .md_start (ex_md_start),
    .md_div   (ex_md_div),
    .md_busy  (md_busy)
  );

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      data_stall_cnt <= '0;
      md_stall_cnt   <= '0;
    end else begin
      if (data_stall && !(&data_stall_cnt)) data_stall_cnt <= data_stall_cnt + 1'b1;
      if (md_stall && !(&md_stall_cnt))     md_stall_cnt   <= md_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl_mdu.sv
// Directed plus randomized bench for hazard_ctrl_mdu against an integer-level
// reference model of the stall, forwarding and MDU-occupancy rules.
module tb_hazard_ctrl_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, ex_wa;
  logic [4:0]  mem_rt_addr, mem_wa, wb_wa;
  logic [1:0]  id_rs_tuse, id_rt_tuse, ex_tnew, mem_tnew;
  logic [31:0] id_rs_data, id_rt_data, ex_rs_data, ex_rt_data, ex_wd;
  logic [31:0] mem_rt_data, mem_wd, wb_wd;
  logic        id_is_md, ex_md_start, ex_md_div;
  logic [31:0] id_rs_fwd, id_rt_fwd, ex_rs_fwd, ex_rt_fwd, mem_rt_fwd;
  logic        stall, en_pc, en_if_id, flush_id_ex, md_busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] data_stall_cnt, md_stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // Reference state: cycles of MDU occupancy left, sticky misuse flag.
  int m_left = 0;
  bit m_err  = 0;
  int m_dcnt = 0;
  int m_mcnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl_mdu dut (
    .clk(clk), .reset(reset),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_tuse(id_rs_tuse), .id_rt_tuse(id_rt_tuse),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_is_md(id_is_md),
    .ex_rs_addr(ex_rs_addr), .ex_rt_addr(ex_rt_addr),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_wa(ex_wa), .ex_tnew(ex_tnew), .ex_wd(ex_wd),
    .ex_md_start(ex_md_start), .ex_md_div(ex_md_div),
    .mem_rt_addr(mem_rt_addr), .mem_rt_data(mem_rt_data),
    .mem_wa(mem_wa), .mem_tnew(mem_tnew), .mem_wd(mem_wd),
    .wb_wa(wb_wa), .wb_wd(wb_wd),
    .id_rs_fwd(id_rs_fwd), .id_rt_fwd(id_rt_fwd),
    .ex_rs_fwd(ex_rs_fwd), .ex_rt_fwd(ex_rt_fwd), .mem_rt_fwd(mem_rt_fwd),
    .stall(stall), .en_pc(en_pc), .en_if_id(en_if_id),
    .flush_id_ex(flush_id_ex), .md_busy(md_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .data_stall_cnt(data_stall_cnt), .md_stall_cnt(md_stall_cnt)
`endif
  );

  function automatic bit ref_data_stall();
    int src_a[2], src_u[2];
    src_a[0] = id_rs_addr; src_u[0] = id_rs_tuse;
    src_a[1] = id_rt_addr; src_u[1] = id_rt_tuse;
    for (int s = 0; s < 2; s++) begin
      if (src_a[s] != 0 && src_a[s] == ex_wa  && src_u[s] < ex_tnew)  return 1;
      if (src_a[s] != 0 && src_a[s] == mem_wa && src_u[s] < mem_tnew) return 1;
    end
    return 0;
  endfunction

  function automatic bit ref_md_stall();
    return id_is_md && (m_left > 0 || ex_md_start);
  endfunction

  // stage: 0 = ID (EX,MEM,WB), 1 = EX (MEM,WB), 2 = MEM (WB)
  function automatic logic [31:0] ref_fwd(int stage, int addr, logic [31:0] pipe);
    if (addr == 0) return 0;
    if (stage == 0 && addr == ex_wa && ex_tnew == 0) return ex_wd;
    if (stage <= 1 && addr == mem_wa && mem_tnew == 0) return mem_wd;
    if (addr == wb_wa) return wb_wd;
    return pipe;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_left = 0; m_err = 0; m_dcnt = 0; m_mcnt = 0;
    end else begin
      if (ref_data_stall()) m_dcnt++;
      if (ref_md_stall())   m_mcnt++;
      if (ex_md_start && m_left == 0) m_left = ex_md_div ? 10 : 5;
      else begin
        if (ex_md_start) m_err = 1;
        if (m_left > 0) m_left--;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {id_rs_addr, id_rt_addr, ex_rs_addr, ex_rt_addr, ex_wa, mem_rt_addr, mem_wa, wb_wa} = '0;
    {id_rs_tuse, id_rt_tuse, ex_tnew, mem_tnew} = '0;
    {id_rs_data, id_rt_data, ex_rs_data, ex_rt_data, ex_wd} = '0;
    {mem_rt_data, mem_wd, wb_wd} = '0;
    {id_is_md, ex_md_start, ex_md_div} = '0;
  endtask

  task automatic chk_all(input string tag);
    bit st;
    st = ref_data_stall() || ref_md_stall();
    chk({tag, ".stall"}, stall, st);
    chk({tag, ".en_pc"}, en_pc, !st);
    chk({tag, ".en_if_id"}, en_if_id, !st);
    chk({tag, ".flush"}, flush_id_ex, st);
    chk({tag, ".md_busy"}, md_busy, m_left > 0);
    chk({tag, ".id_rs_fwd"}, id_rs_fwd, ref_fwd(0, id_rs_addr, id_rs_data));
    chk({tag, ".id_rt_fwd"}, id_rt_fwd, ref_fwd(0, id_rt_addr, id_rt_data));
    chk({tag, ".ex_rs_fwd"}, ex_rs_fwd, ref_fwd(1, ex_rs_addr, ex_rs_data));
    chk({tag, ".ex_rt_fwd"}, ex_rt_fwd, ref_fwd(1, ex_rt_addr, ex_rt_data));
    chk({tag, ".mem_rt_fwd"}, mem_rt_fwd, ref_fwd(2, mem_rt_addr, mem_rt_data));
  endtask

  initial begin
    int busy_cyc, stall_cyc;
    idle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.md_busy", md_busy, 0);
    chk("reset.stall", stall, 0);
    chk("reset.en_pc", en_pc, 1);
    chk("reset.en_if_id", en_if_id, 1);
    chk("reset.flush", flush_id_ex, 0);
    chk("reset.md_err", dut.u_tracker.md_err, 0);
    reset = 1'b0;

    // Load-use: lw $1 in EX, consumer in ID
    id_rs_addr = 5'd1; id_rs_tuse = 2'd1; ex_wa = 5'd1; ex_tnew = 2'd2;
    #1;
    chk("lw_ex.stall", stall, 1);
    chk("lw_ex.en_pc", en_pc, 0);
    chk("lw_ex.flush", flush_id_ex, 1);
    @(negedge clk);
    ex_wa = 5'd0; ex_tnew = 2'd0; mem_wa = 5'd1; mem_tnew = 2'd1;
    #1;
    chk("lw_mem.stall", stall, 0);

    // ori result forwarded from EX
    @(negedge clk); idle();
    id_rs_addr = 5'd2; id_rs_tuse = 2'd0; ex_wa = 5'd2; ex_tnew = 2'd0;
    ex_wd = 32'h1234; id_rs_data = 32'h5555;
    #1;
    chk("ori.id_rs_fwd", id_rs_fwd, 32'h1234);
    chk("ori.stall", stall, 0);
    id_rs_addr = 5'd0; ex_wa = 5'd0;
    #1;
    chk("zero.id_rs_fwd", id_rs_fwd, 32'h0);

    // MEM beats WB for EX operand; WB feeds MEM store data
    idle();
    ex_rs_addr = 5'd3; mem_rt_addr = 5'd3; mem_wa = 5'd3; mem_tnew = 2'd0;
    mem_wd = 32'hA; wb_wa = 5'd3; wb_wd = 32'hB; ex_rs_data = 32'hC; mem_rt_data = 32'hD;
    #1;
    chk("prio.ex_rs_fwd", ex_rs_fwd, 32'hA);
    chk("prio.mem_rt_fwd", mem_rt_fwd, 32'hB);

    // div start with mflo waiting in ID
    @(negedge clk); idle();
    ex_md_start = 1'b1; ex_md_div = 1'b1; id_is_md = 1'b1;
    busy_cyc = 0; stall_cyc = 0;
    #1;
    if (stall) stall_cyc++;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      ex_md_start = 1'b0;
      #1;
      if (md_busy) busy_cyc++;
      if (stall) stall_cyc++;
    end
    chk("div.busy_cycles", busy_cyc, 10);
    chk("div.stall_cycles", stall_cyc, 11);
    chk("div.released", stall, 0);

    // mult aborted by reset in its second cycle
    @(negedge clk); idle();
    ex_md_start = 1'b1;
    @(negedge clk); ex_md_start = 1'b0; #1;
    chk("mult.busy1", md_busy, 1);
    @(negedge clk); reset = 1'b1; #1;
    chk("mult.busy2", md_busy, 1);
    @(negedge clk); reset = 1'b0; #1;
    chk("mult.abort", md_busy, 0);

    // Second start while busy is ignored and flagged
    ex_md_start = 1'b1;
    @(negedge clk); #1;
    @(negedge clk); ex_md_start = 1'b0; #1;
    chk("err.md_err", dut.u_tracker.md_err, 1);
    chk("err.busy", md_busy, 1);

    // Randomized traffic against the reference model
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      reset       = ($urandom_range(0, 59) == 0);
      id_rs_addr  = 5'($urandom_range(0, 3)); id_rt_addr  = 5'($urandom_range(0, 3));
      ex_rs_addr  = 5'($urandom_range(0, 3)); ex_rt_addr  = 5'($urandom_range(0, 3));
      mem_rt_addr = 5'($urandom_range(0, 3));
      ex_wa  = 5'($urandom_range(0, 3)); mem_wa = 5'($urandom_range(0, 3));
      wb_wa  = 5'($urandom_range(0, 3));
      id_rs_tuse = 2'($urandom_range(0, 2)); id_rt_tuse = 2'($urandom_range(0, 2));
      ex_tnew    = 2'($urandom_range(0, 2)); mem_tnew   = 2'($urandom_range(0, 1));
      id_rs_data = $urandom; id_rt_data = $urandom; ex_rs_data = $urandom;
      ex_rt_data = $urandom; ex_wd = $urandom; mem_rt_data = $urandom;
      mem_wd = $urandom; wb_wd = $urandom;
      id_is_md    = ($urandom_range(0, 2) == 0);
      ex_md_start = ($urandom_range(0, 9) == 0);
      ex_md_div   = $urandom_range(0, 1);
      #1;
      chk_all("rand");
    end
    @(negedge clk); reset = 1'b0; idle(); #1;
    chk("rand.md_err", dut.u_tracker.md_err, m_err);

`ifdef HAZARD_PERF_CNT_EN
    chk("perf.data", data_stall_cnt, m_dcnt);
    chk("perf.md", md_stall_cnt, m_mcnt);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
